// File: rtl/rv_exec_pkg.sv
// Shared definitions for the execution bank: ALU opcodes, FU state encoding,
// the CDB broadcast payload and the round-robin pointer helper.
package rv_exec_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [1:0] {
    FU_IDLE = 2'd0,
    FU_EXEC = 2'd1,
    FU_DONE = 2'd2
  } fu_state_e;

  typedef struct packed {
    logic [5:0]  tag;
    logic [5:0]  rob;
    logic [31:0] value;
    logic        is_ls;
    logic [31:0] store_data;
    logic [1:0]  fu;
  } cdb_pkt_t;

  // (base + off) mod 3 for the three-entry round-robin ring.
  function automatic logic [1:0] rr_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

endpackage

// File: rtl/fu_alu.sv
// Combinational FU datapath. Load/store ops produce rs1 + imm; opcode 12
// multiplies only when FU_MUL_EN is defined, otherwise it yields 0.
module fu_alu
  import rv_exec_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_is_ls,
  input  logic [31:0] i_imm,
  output logic [31:0] o_result
);

  logic signed [31:0] w_a_s;
  assign w_a_s = i_a;

  // NOTE: o_result gets a default before any branch so no path infers a latch.
  always_comb begin
    o_result = '0;
    if (i_is_ls) begin
      o_result = i_a + i_imm;
    end else begin
      case (i_opcode)
        OP_ADD:  o_result = i_a + i_b;
        OP_SUB:  o_result = i_a - i_b;
        OP_AND:  o_result = i_a & i_b;
        OP_OR:   o_result = i_a | i_b;
        OP_XOR:  o_result = i_a ^ i_b;
        OP_SLL:  o_result = i_a << i_b[4:0];
        OP_SRL:  o_result = i_a >> i_b[4:0];
        OP_SRA:  o_result = w_a_s >>> i_b[4:0];
        OP_SLT:  o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
        OP_SLTU: o_result = {31'd0, (i_a < i_b)};
        OP_LUI:  o_result = i_imm;
`ifdef FU_MUL_EN
        OP_MUL:  o_result = i_a * i_b;
`endif
        default: o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/functional_unit_bank.sv
// Three execution units sharing one registered CDB with round-robin grant.
// Define FU_MUL_EN to run opcode 12 as a MUL_LATENCY-cycle multiply.
module functional_unit_bank
  import rv_exec_pkg::*;
#(
  parameter int NUM_FU      = 3,
  parameter int MUL_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_FU-1:0]      issue_valid,
  input  logic [NUM_FU-1:0][3:0] issue_alu_type,
  input  logic [NUM_FU-1:0]      issue_alusrc,
  input  logic [NUM_FU-1:0]      issue_is_ls,
  input  logic [NUM_FU-1:0][31:0] issue_rs1_val,
  input  logic [NUM_FU-1:0][31:0] issue_rs2_val,
  input  logic [NUM_FU-1:0][31:0] issue_imm,
  input  logic [NUM_FU-1:0][5:0] issue_rd_tag,
  input  logic [NUM_FU-1:0][5:0] issue_rob_num,
  output logic [NUM_FU-1:0]      fu_ready,
  output logic                   cdb_valid,
  output logic [5:0]             cdb_rd_tag,
  output logic [5:0]             cdb_rob_num,
  output logic [31:0]            cdb_value,
  output logic                   cdb_is_ls,
  output logic [31:0]            cdb_store_data,
  output logic [1:0]             cdb_fu,
  output logic                   issue_overrun
);

  if (NUM_FU != 3) begin : g_bad_num_fu
    $error("functional_unit_bank supports exactly three FUs");
  end
  if (MUL_LATENCY < 1) begin : g_bad_mul_latency
    $error("MUL_LATENCY must be at least 1");
  end

  fu_state_e r_state     [NUM_FU];
  fu_state_e w_state_nxt [NUM_FU];
  cdb_pkt_t  r_pkt       [NUM_FU];
  cdb_pkt_t  r_cdb;
  logic      r_cdb_valid;
  logic [1:0] r_rr_ptr;
  logic      r_overrun;
  logic      w_grant_vld;
  logic [1:0] w_grant_idx;

  logic [NUM_FU-1:0][3:0]  w_alu_op;
  logic [NUM_FU-1:0][31:0] w_alu_a;
  logic [NUM_FU-1:0][31:0] w_alu_b;
  logic [NUM_FU-1:0]       w_alu_ls;
  logic [NUM_FU-1:0][31:0] w_alu_res;
  logic [NUM_FU-1:0][31:0] w_opb;
  logic [NUM_FU-1:0]       w_done;

`ifdef FU_MUL_EN
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  logic [CNT_W-1:0] r_cnt   [NUM_FU];
  logic [31:0]      r_mul_a [NUM_FU];
  logic [31:0]      r_mul_b [NUM_FU];
  logic [NUM_FU-1:0] w_in_exec;
  logic [NUM_FU-1:0] w_issue_mul;
`endif

  for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
    assign w_opb[k]  = issue_alusrc[k] ? issue_imm[k] : issue_rs2_val[k];
    assign w_done[k] = (r_state[k] == FU_DONE);
`ifdef FU_MUL_EN
    // While in EXEC the ALU is fed the latched MUL operands instead of the issue port.
    assign w_in_exec[k]   = (r_state[k] == FU_EXEC);
    assign w_issue_mul[k] = (issue_alu_type[k] == OP_MUL) && !issue_is_ls[k];
    assign w_alu_op[k]    = w_in_exec[k] ? OP_MUL : issue_alu_type[k];
    assign w_alu_a[k]     = w_in_exec[k] ? r_mul_a[k] : issue_rs1_val[k];
    assign w_alu_b[k]     = w_in_exec[k] ? r_mul_b[k] : w_opb[k];
    assign w_alu_ls[k]    = !w_in_exec[k] && issue_is_ls[k];
`else
    assign w_alu_op[k]    = issue_alu_type[k];
    assign w_alu_a[k]     = issue_rs1_val[k];
    assign w_alu_b[k]     = w_opb[k];
    assign w_alu_ls[k]    = issue_is_ls[k];
`endif

    fu_alu u_alu (
      .i_opcode (w_alu_op[k]),
      .i_a      (w_alu_a[k]),
      .i_b      (w_alu_b[k]),
      .i_is_ls  (w_alu_ls[k]),
      .i_imm    (issue_imm[k]),
      .o_result (w_alu_res[k])
    );
  end

  // Lowest offset from rr_ptr wins, so scan offsets from the far end down.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = 2'd0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (w_done[rr_add(r_rr_ptr, 2'(i))]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = rr_add(r_rr_ptr, 2'(i));
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      w_state_nxt[k] = r_state[k];
      fu_ready[k]    = (r_state[k] == FU_IDLE);
      case (r_state[k])
        FU_IDLE: if (issue_valid[k]) begin
`ifdef FU_MUL_EN
          w_state_nxt[k] = w_issue_mul[k] ? FU_EXEC : FU_DONE;
`else
          w_state_nxt[k] = FU_DONE;
`endif
        end
`ifdef FU_MUL_EN
        FU_EXEC: if (r_cnt[k] == '0) w_state_nxt[k] = FU_DONE;
`endif
        FU_DONE: if (w_grant_vld && (w_grant_idx == 2'(k))) w_state_nxt[k] = FU_IDLE;
        default: w_state_nxt[k] = FU_IDLE;
      endcase
    end
  end

  // NOTE: payload, operand and counter registers are not reset; r_state gates every use of them.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_FU; k++) begin
      if ((r_state[k] == FU_IDLE) && issue_valid[k]) begin
        r_pkt[k].tag        <= issue_rd_tag[k];
        r_pkt[k].rob        <= issue_rob_num[k];
        r_pkt[k].value      <= w_alu_res[k];
        r_pkt[k].is_ls      <= issue_is_ls[k];
        r_pkt[k].store_data <= issue_is_ls[k] ? issue_rs2_val[k] : '0;
        r_pkt[k].fu         <= 2'(k);
`ifdef FU_MUL_EN
        r_mul_a[k] <= issue_rs1_val[k];
        r_mul_b[k] <= w_opb[k];
        r_cnt[k]   <= CNT_W'(MUL_LATENCY - 1);
      end else if (r_state[k] == FU_EXEC) begin
        if (r_cnt[k] == '0) r_pkt[k].value <= w_alu_res[k];
        else                r_cnt[k]       <= r_cnt[k] - 1'b1;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_FU; k++) r_state[k] <= FU_IDLE;
      r_cdb_valid <= 1'b0;
      r_cdb       <= '0;
      r_rr_ptr    <= 2'd0;
      r_overrun   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) r_state[k] <= w_state_nxt[k];
      r_cdb_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_cdb    <= r_pkt[w_grant_idx];
        r_rr_ptr <= rr_add(w_grant_idx, 2'd1);
      end
      if (|(issue_valid & ~fu_ready)) r_overrun <= 1'b1;
    end
  end

  assign cdb_valid      = r_cdb_valid;
  assign cdb_rd_tag     = r_cdb.tag;
  assign cdb_rob_num    = r_cdb.rob;
  assign cdb_value      = r_cdb.value;
  assign cdb_is_ls      = r_cdb.is_ls;
  assign cdb_store_data = r_cdb.store_data;
  assign cdb_fu         = r_cdb.fu;
  assign issue_overrun  = r_overrun;

endmodule

// File: tb/tb_functional_unit_bank.sv
// Scoreboard bench for functional_unit_bank: directed scenarios then random
// traffic, checked against a cycle-level reference model of the bank.
module tb_functional_unit_bank;

  localparam int MUL_LAT = 3;

  typedef struct {
    logic [5:0]  tag;
    logic [5:0]  rob;
    logic [31:0] value;
    logic        is_ls;
    logic [31:0] sd;
    logic [1:0]  fu;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0]       iv = '0;
  logic [2:0][3:0]  op = '0;
  logic [2:0]       alusrc = '0;
  logic [2:0]       is_ls = '0;
  logic [2:0][31:0] rs1 = '0;
  logic [2:0][31:0] rs2 = '0;
  logic [2:0][31:0] imm = '0;
  logic [2:0][5:0]  tag = '0;
  logic [2:0][5:0]  rob = '0;
  logic [2:0]       fu_ready;
  logic             cdb_valid;
  logic [5:0]       cdb_rd_tag;
  logic [5:0]       cdb_rob_num;
  logic [31:0]      cdb_value;
  logic             cdb_is_ls;
  logic [31:0]      cdb_store_data;
  logic [1:0]       cdb_fu;
  logic             issue_overrun;

  functional_unit_bank #(.NUM_FU(3), .MUL_LATENCY(MUL_LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (iv),
    .issue_alu_type (op),
    .issue_alusrc   (alusrc),
    .issue_is_ls    (is_ls),
    .issue_rs1_val  (rs1),
    .issue_rs2_val  (rs2),
    .issue_imm      (imm),
    .issue_rd_tag   (tag),
    .issue_rob_num  (rob),
    .fu_ready       (fu_ready),
    .cdb_valid      (cdb_valid),
    .cdb_rd_tag     (cdb_rd_tag),
    .cdb_rob_num    (cdb_rob_num),
    .cdb_value      (cdb_value),
    .cdb_is_ls      (cdb_is_ls),
    .cdb_store_data (cdb_store_data),
    .cdb_fu         (cdb_fu),
    .issue_overrun  (issue_overrun)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_edge   = 0;
  exp_t q[$];
  bit   m_pend[3];
  int   m_rem[3];
  exp_t m_held[3];
  int   m_rr = 0;
  bit   m_ovr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, n_edge);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: cdb_valid=%0b at edge %0d, expected broadcasts queued=%0d",
             name, cdb_valid, n_edge, q.size());
  endtask

  function automatic bit is_mul(input logic [3:0] o, input logic ls);
`ifdef FU_MUL_EN
    return (o == 4'd12) && !ls;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] im,
                                             input logic ls);
    int sh;
    sh = int'(b % 32);
    if (ls) return a + im;
    case (o)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return a ^ b;
      4'd6:  return a << sh;
      4'd7:  return a >> sh;
      4'd8:  return $unsigned($signed(a) >>> sh);
      4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      4'd11: return im;
`ifdef FU_MUL_EN
      4'd12: return a * b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input int k, input logic [3:0] o, input logic src, input logic ls,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [5:0] t, input logic [5:0] r);
    iv[k] = 1'b1; op[k] = o; alusrc[k] = src; is_ls[k] = ls;
    rs1[k] = a; rs2[k] = b; imm[k] = im; tag[k] = t; rob[k] = r;
  endtask

  // One clock: advance the model with the inputs sampled at this edge,
  // then check ready/overrun away from the edge and drop issue_valid.
  task automatic tick();
    bit   newi[3];
    int   g;
    int   c;
    exp_t e;
    @(posedge clk);
    n_edge++;
    if (reset) begin
      for (int k = 0; k < 3; k++) m_pend[k] = 1'b0;
      m_rr  = 0;
      m_ovr = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        newi[k] = 1'b0;
        if (iv[k]) begin
          if (m_pend[k]) m_ovr = 1'b1;
          else           newi[k] = 1'b1;
        end
      end
      g = -1;
      for (int i = 0; i < 3; i++) begin
        c = (m_rr + i) % 3;
        if (g < 0 && m_pend[c] && m_rem[c] == 0) g = c;
      end
      for (int k = 0; k < 3; k++)
        if (m_pend[k] && m_rem[k] > 0) m_rem[k]--;
      if (g >= 0) begin
        e = m_held[g];
        e.fu  = 2'(g);
        e.cyc = n_edge;
        q.push_back(e);
        m_pend[g] = 1'b0;
        m_rr = (g + 1) % 3;
      end
      for (int k = 0; k < 3; k++) begin
        if (newi[k]) begin
          m_pend[k]       = 1'b1;
          m_rem[k]        = is_mul(op[k], is_ls[k]) ? MUL_LAT : 0;
          m_held[k].tag   = tag[k];
          m_held[k].rob   = rob[k];
          m_held[k].value = ref_result(op[k], rs1[k], alusrc[k] ? imm[k] : rs2[k], imm[k], is_ls[k]);
          m_held[k].is_ls = is_ls[k];
          m_held[k].sd    = is_ls[k] ? rs2[k] : 32'd0;
          m_held[k].fu    = 2'(k);
          m_held[k].cyc   = 0;
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("fu_ready[%0d]", k), fu_ready[k], !m_pend[k]);
    check("issue_overrun", issue_overrun, m_ovr);
    iv = '0;
  endtask

  // Monitor: every broadcast must match the head of the expected queue at its edge.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < n_edge) begin
      fail_now("cdb_missing");
      void'(q.pop_front());
    end
    if (cdb_valid === 1'b1) begin
      if (q.size() == 0 || q[0].cyc != n_edge) begin
        fail_now("cdb_unexpected");
      end else begin
        e = q.pop_front();
        check("cdb_rd_tag", cdb_rd_tag, e.tag);
        check("cdb_rob_num", cdb_rob_num, e.rob);
        check("cdb_value", cdb_value, e.value);
        check("cdb_is_ls", cdb_is_ls, e.is_ls);
        check("cdb_store_data", cdb_store_data, e.sd);
        check("cdb_fu", cdb_fu, e.fu);
      end
    end
  end

  initial begin
    // Reset held two cycles.
    reset = 1'b1;
    tick();
    tick();
    check("rst_fu_ready", fu_ready, 3'b111);
    check("rst_cdb_valid", cdb_valid, 1'b0);
    check("rst_overrun", issue_overrun, 1'b0);
    check("rst_cdb_value", cdb_value, 32'd0);
    check("rst_cdb_tag", cdb_rd_tag, 6'd0);
    reset = 1'b0;
    tick();

    // Three FUs complete together, rr_ptr = 0.
    issue(0, 4'd2,  1'b0, 1'b0, 32'd10,         32'd3, 32'd0, 6'd1, 6'd1);
    issue(1, 4'd8,  1'b0, 1'b0, 32'h8000_0000,  32'd4, 32'd0, 6'd2, 6'd2);
    issue(2, 4'd10, 1'b0, 1'b0, 32'd1,          32'd2, 32'd0, 6'd3, 6'd3);
    tick();
    tick();
    check("tri_fu0_valid", cdb_valid, 1'b1);
    check("tri_fu0_fu", cdb_fu, 2'd0);
    check("tri_fu0_value", cdb_value, 32'd7);
    tick();
    check("tri_fu1_fu", cdb_fu, 2'd1);
    check("tri_fu1_value", cdb_value, 32'hF800_0000);
    tick();
    check("tri_fu2_fu", cdb_fu, 2'd2);
    check("tri_fu2_value", cdb_value, 32'd1);
    tick();
    check("tri_idle_valid", cdb_valid, 1'b0);
    check("tri_hold_value", cdb_value, 32'd1);

    // Single ADD with immediate on FU0.
    issue(0, 4'd1, 1'b1, 1'b0, 32'd5, 32'd100, 32'd7, 6'd9, 6'd3);
    tick();
    check("add_not_yet", cdb_valid, 1'b0);
    tick();
    check("add_valid", cdb_valid, 1'b1);
    check("add_value", cdb_value, 32'd12);
    check("add_tag", cdb_rd_tag, 6'd9);
    check("add_rob", cdb_rob_num, 6'd3);
    check("add_fu", cdb_fu, 2'd0);
    tick();

    // Overrun: second issue to FU1 while it sits in DONE.
    issue(1, 4'd1, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 6'd4, 6'd4);
    tick();
    issue(1, 4'd1, 1'b0, 1'b0, 32'd100, 32'd200, 32'd0, 6'd5, 6'd5);
    tick();
    check("ovr_flag", issue_overrun, 1'b1);
    check("ovr_value", cdb_value, 32'd3);
    check("ovr_tag", cdb_rd_tag, 6'd4);
    tick();
    tick();
    check("ovr_sticky", issue_overrun, 1'b1);
    check("ovr_dropped", cdb_valid, 1'b0);

    // Load/store address on FU2.
    issue(2, 4'd5, 1'b1, 1'b1, 32'h1000, 32'hAB, 32'h10, 6'd6, 6'd6);
    tick();
    tick();
    check("ls_value", cdb_value, 32'h1010);
    check("ls_is_ls", cdb_is_ls, 1'b1);
    check("ls_store_data", cdb_store_data, 32'hAB);
    check("ls_fu", cdb_fu, 2'd2);
    tick();

    // MUL 6 x 7 on FU0.
    issue(0, 4'd12, 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 6'd7, 6'd7);
`ifdef FU_MUL_EN
    for (int i = 0; i < MUL_LAT + 1; i++) begin
      tick();
      check("mul_wait_valid", cdb_valid, 1'b0);
      check("mul_busy", fu_ready[0], 1'b0);
    end
    tick();
    check("mul_valid", cdb_valid, 1'b1);
    check("mul_value", cdb_value, 32'd42);
`else
    tick();
    tick();
    check("mul_valid", cdb_valid, 1'b1);
    check("mul_value", cdb_value, 32'd0);
`endif
    tick();

    // Reset mid-operation discards in-flight results.
    issue(0, 4'd1, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 6'd10, 6'd10);
    issue(1, 4'd1, 1'b0, 1'b0, 32'd2, 32'd2, 32'd0, 6'd11, 6'd11);
    issue(2, 4'd12, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0, 6'd12, 6'd12);
    tick();
    reset = 1'b1;
    tick();
    check("mrst_valid", cdb_valid, 1'b0);
    check("mrst_ready", fu_ready, 3'b111);
    check("mrst_overrun", issue_overrun, 1'b0);
    reset = 1'b0;
    tick();
    check("mrst_no_bcast", cdb_valid, 1'b0);

    // Random traffic; issues to busy FUs are rare so overrun stays a side case.
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(99) < (m_pend[k] ? 4 : 60)) begin
          logic [3:0]  o;
          logic        ls;
          logic [31:0] a;
          logic [31:0] b;
          ls = ($urandom_range(99) < 20);
          o  = 4'($urandom_range(15));
          if (ls && o == 4'd12) o = 4'd1;
          a  = ($urandom_range(3) == 0) ? 32'($urandom_range(8)) : $urandom;
          b  = ($urandom_range(3) == 0) ? 32'($urandom_range(8)) : $urandom;
          issue(k, o, 1'($urandom_range(1)), ls, a, b, $urandom,
                6'($urandom_range(63)), 6'($urandom_range(63)));
        end
      end
      tick();
    end

    repeat (10) tick();
    check("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
